// File: rtl/idc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idc_pkg
//  Description : Shared opcode constants, immediate-class enumeration,
//                decoded-field record and XLEN legality check for the
//                instruction decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package idc_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    // Width-independent part of a decoded entry
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] cmd_op;
        logic [2:0] func3;
        logic [6:0] func7;
        imm_type_e  imm_type;
    } fields_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Any opcode not listed carries no immediate
    function automatic imm_type_e imm_class(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC:                      return IMM_U;
            OP_JAL:                                return IMM_J;
            OP_BRANCH:                             return IMM_B;
            OP_STORE:                              return IMM_S;
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:   return IMM_I;
            default:                               return IMM_R;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/idc_fields.sv
`default_nettype none
// ============================================================================
//  Module      : idc_fields
//  Description : Purely combinational field extraction and immediate
//                construction (RV32I layout, sign-extended to XLEN).
//                Optional macro IDC_ILLEGAL_EN adds the illegal output.
//  Revision    : 1.0 - initial release
// ============================================================================
module idc_fields
    import idc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fields_t         fields,
    output logic [XLEN-1:0] imm
`ifdef IDC_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    imm_type_e   cls;
    logic [31:0] imm32;

    // Register fields and immediate class straight from the instruction bits
    always_comb begin
        cls             = imm_class(instr[6:0]);
        fields.rs1      = instr[19:15];
        fields.rs2      = instr[24:20];
        fields.rd       = instr[11:7];
        fields.cmd_op   = instr[6:0];
        fields.func3    = instr[14:12];
        fields.func7    = instr[31:25];
        fields.imm_type = cls;
    end

    // 32-bit immediate assembled per class; unknown opcodes yield zero
    always_comb begin
        imm32 = '0;
        case (cls)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Bit 31 extends through the upper word when XLEN is 64
    assign imm = XLEN'($signed(imm32));

`ifdef IDC_ILLEGAL_EN
    // Every supported opcode ends in 2'b11, so class R covers both cases
    assign illegal = (cls == IMM_R);
`endif

endmodule
`default_nettype wire

// File: rtl/idc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : idc_stage
//  Description : Decode stage: combinational decode of in_instr registered
//                with in_pc into a skid buffer (SKID=1) or a single register
//                (SKID=0) with valid/ready handshake and flush.
//                Optional macro IDC_ILLEGAL_EN adds the illegal output.
//  Revision    : 1.0 - initial release
// ============================================================================
module idc_stage
    import idc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      cmd_op,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
`ifdef IDC_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("idc_stage: XLEN must be 32 or 64");
    end

`ifdef IDC_ILLEGAL_EN
    localparam int ILL_W = 1;
`else
    localparam int ILL_W = 0;
`endif
    localparam int EW = 2 * XLEN + $bits(fields_t) + ILL_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            ready_q;
    logic            accept;
    logic            drain;
    fields_t         dec_fields;
    logic [XLEN-1:0] dec_imm;
    logic [EW-1:0]   dec_entry;
    logic [EW-1:0]   head;
    logic [EW-1:0]   skid;
    fields_t         head_fields;

    idc_fields #(.XLEN(XLEN)) u_fields (
        .instr   (in_instr),
        .fields  (dec_fields),
        .imm     (dec_imm)
`ifdef IDC_ILLEGAL_EN
        ,
        .illegal (dec_entry[0])
`endif
    );

    assign dec_entry[EW-1:ILL_W] = {in_pc, dec_imm, dec_fields};

`ifdef IDC_ILLEGAL_EN
    assign {out_pc, imm, head_fields, illegal} = head;
`else
    assign {out_pc, imm, head_fields} = head;
`endif

    assign rs1      = head_fields.rs1;
    assign rs2      = head_fields.rs2;
    assign rd       = head_fields.rd;
    assign cmd_op   = head_fields.cmd_op;
    assign func3    = head_fields.func3;
    assign func7    = head_fields.func7;
    assign imm_type = head_fields.imm_type;

    // A flush-cycle instruction is never taken
    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_valid && out_ready;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    // Occupancy next-state; simultaneous accept and drain holds the count
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_next = ST_TWO;
                    else if (!accept && drain) state_next = ST_EMPTY;
                end
                ST_TWO:   if (drain)  state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Registered ready for the skid variant: low only when both slots fill
    always_ff @(posedge clk) begin
        if (!rst_n) ready_q <= 1'b1;
        else        ready_q <= (state_next != ST_TWO);
    end

    // Handshake outputs; in_ready is forced low while reset is held
    always_comb begin
        out_valid = (state != ST_EMPTY);
        if (SKID != 0) in_ready = ready_q && rst_n;
        else           in_ready = ((state == ST_EMPTY) || out_ready) && rst_n;
    end

    // Head entry: promote the skid slot on drain, else load a fresh decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
        end else if (!flush) begin
            if (state == ST_TWO && drain)
                head <= skid;
            else if (accept && (state == ST_EMPTY || drain))
                head <= dec_entry;
        end
    end

    if (SKID != 0) begin : g_skid
        // Second slot catches an accept while the head is stalled
        always_ff @(posedge clk) begin
            if (!rst_n)
                skid <= '0;
            else if (!flush && accept && state == ST_ONE && !drain)
                skid <= dec_entry;
        end
    end else begin : g_single
        assign skid = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_idc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idc_stage
//  Description : Bench for idc_stage: a 32-bit skid-buffer instance and a
//                64-bit single-register instance share one stimulus stream;
//                a queue model predicts each output stream.
//                Macro IDC_ILLEGAL_EN enables the illegal-port checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idc_stage;

    localparam logic [63:0] MASK32 = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_cmd_op, a_func7;
    logic [2:0]  a_func3, a_imm_type;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_cmd_op, b_func7;
    logic [2:0]  b_func3, b_imm_type;
`ifdef IDC_ILLEGAL_EN
    logic        a_illegal, b_illegal;
`endif

    idc_stage #(.XLEN(32), .SKID(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .cmd_op(a_cmd_op),
        .func3(a_func3), .func7(a_func7), .imm_type(a_imm_type), .imm(a_imm)
`ifdef IDC_ILLEGAL_EN
        , .illegal(a_illegal)
`endif
    );

    idc_stage #(.XLEN(64), .SKID(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .cmd_op(b_cmd_op),
        .func3(b_func3), .func7(b_func7), .imm_type(b_imm_type), .imm(b_imm)
`ifdef IDC_ILLEGAL_EN
        , .illegal(b_illegal)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [31:0] fld;
        logic        ill;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   run = 0;
    bit   rz  = 0;
    bit   acc_a, drn_a, acc_b, drn_b;

    // Reference decode: immediate computed with shifts and masks on a
    // 64-bit sign-extended copy of the instruction
    function automatic exp_t decode_ref(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        logic [63:0] sx, w;
        sx    = ins[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
        w     = {32'd0, ins};
        e.pc  = pc;
        e.fld = {ins[19:15], ins[24:20], ins[11:7], ins[6:0], ins[14:12], ins[31:25]};
        e.ill = 1'b0;
        e.imm = 64'd0;
        e.typ = 3'd0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                e.typ = 3'd4;
                e.imm = (sx << 32) | (w & 64'hFFFF_F000);
            end
            7'h6F: begin
                e.typ = 3'd5;
                e.imm = (sx << 20) | (w & 64'h000F_F000) | (((w >> 20) & 64'h1) << 11)
                      | (((w >> 21) & 64'h3FF) << 1);
            end
            7'h63: begin
                e.typ = 3'd3;
                e.imm = (sx << 12) | (((w >> 7) & 64'h1) << 11) | (((w >> 25) & 64'h3F) << 5)
                      | (((w >> 8) & 64'hF) << 1);
            end
            7'h23: begin
                e.typ = 3'd2;
                e.imm = (sx << 11) | (((w >> 25) & 64'h3F) << 5) | ((w >> 7) & 64'h1F);
            end
            7'h03, 7'h13, 7'h67, 7'h73: begin
                e.typ = 3'd1;
                e.imm = (sx << 11) | ((w >> 20) & 64'h7FF);
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model update on each edge: push on acceptance, pop on drain
    always @(posedge clk) begin
        acc_a = in_valid && rst_n && !flush && (q_a.size() < 2);
        drn_a = (q_a.size() > 0) && out_ready;
        acc_b = in_valid && rst_n && !flush && (q_b.size() == 0 || out_ready);
        drn_b = (q_b.size() > 0) && out_ready;
        if (!rst_n || flush) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (drn_a) void'(q_a.pop_front());
            if (acc_a) q_a.push_back(decode_ref(in_instr, in_pc));
            if (drn_b) void'(q_b.pop_front());
            if (acc_b) q_b.push_back(decode_ref(in_instr, in_pc));
        end
        rz = !rst_n;
    end

    // Monitor: compare presented outputs against the head of each queue
    always @(negedge clk) begin
        if (run) begin
            chk("a_out_valid", {63'd0, a_out_valid}, {63'd0, q_a.size() > 0});
            chk("a_in_ready", {63'd0, a_in_ready}, {63'd0, rst_n && q_a.size() < 2});
            chk("b_out_valid", {63'd0, b_out_valid}, {63'd0, q_b.size() > 0});
            chk("b_in_ready", {63'd0, b_in_ready},
                {63'd0, rst_n && (q_b.size() == 0 || out_ready)});
            if (q_a.size() > 0) begin
                chk("a_pc", {32'd0, a_out_pc}, q_a[0].pc & MASK32);
                chk("a_imm", {32'd0, a_imm}, q_a[0].imm & MASK32);
                chk("a_imm_type", {61'd0, a_imm_type}, {61'd0, q_a[0].typ});
                chk("a_fields", {32'd0, a_rs1, a_rs2, a_rd, a_cmd_op, a_func3, a_func7},
                    {32'd0, q_a[0].fld});
`ifdef IDC_ILLEGAL_EN
                chk("a_illegal", {63'd0, a_illegal}, {63'd0, q_a[0].ill});
`endif
            end
            if (q_b.size() > 0) begin
                chk("b_pc", b_out_pc, q_b[0].pc);
                chk("b_imm", b_imm, q_b[0].imm);
                chk("b_imm_type", {61'd0, b_imm_type}, {61'd0, q_b[0].typ});
                chk("b_fields", {32'd0, b_rs1, b_rs2, b_rd, b_cmd_op, b_func3, b_func7},
                    {32'd0, q_b[0].fld});
`ifdef IDC_ILLEGAL_EN
                chk("b_illegal", {63'd0, b_illegal}, {63'd0, q_b[0].ill});
`endif
            end
            if (rz) begin
                chk("a_reset_pc_imm", {a_out_pc, a_imm}, 64'd0);
                chk("a_reset_fields", {29'd0, a_imm_type, a_rs1, a_rs2, a_rd,
                    a_cmd_op, a_func3, a_func7}, 64'd0);
                chk("b_reset_pc", b_out_pc, 64'd0);
                chk("b_reset_imm", b_imm, 64'd0);
                chk("b_reset_fields", {29'd0, b_imm_type, b_rs1, b_rs2, b_rd,
                    b_cmd_op, b_func3, b_func7}, 64'd0);
`ifdef IDC_ILLEGAL_EN
                chk("reset_illegal", {62'd0, a_illegal, b_illegal}, 64'd0);
`endif
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl, input logic rn);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  ops [0:10];
    logic [31:0] r;
    logic [31:0] ins_r;

    initial begin
        ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13, 7'h67, 7'h73, 7'h33, 7'h7F};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        @(posedge clk); #1;
        run = 1'b1;
        drive(0, 32'h0, 64'h0, 0, 0, 0);

        // Decode examples, including the 64-bit U/B cases and an unknown opcode
        drive(1, 32'hFFF00093, 64'h0,  1, 0, 1);
        drive(1, 32'h123452B7, 64'h4,  1, 0, 1);
        drive(1, 32'hFE000EE3, 64'h8,  1, 0, 1);
        drive(1, 32'h0000007F, 64'hC,  1, 0, 1);
        drive(1, 32'h8000006F, 64'hFFFF_FFFF_8000_0010, 1, 0, 1);
        drive(1, 32'hFE112E23, 64'h14, 1, 0, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);

        // Back-pressure: three offers while the output is stalled
        drive(1, 32'h00100093, 64'h0, 0, 0, 1);
        drive(1, 32'h00200113, 64'h4, 0, 0, 1);
        drive(1, 32'h00300193, 64'h8, 0, 0, 1);
        drive(1, 32'h00300193, 64'h8, 0, 0, 1);
        drive(1, 32'h00300193, 64'h8, 1, 0, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);

        // Flush while full with a new instruction offered
        drive(1, 32'h00400213, 64'h20, 0, 0, 1);
        drive(1, 32'h00500293, 64'h24, 0, 0, 1);
        drive(1, 32'h00600313, 64'h28, 0, 1, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);

        // Single-cycle reset with one entry held
        drive(1, 32'h00700393, 64'h30, 0, 0, 1);
        drive(0, 32'h0, 64'h0, 0, 0, 0);
        drive(0, 32'h0, 64'h0, 0, 0, 1);
        drive(0, 32'h0, 64'h0, 1, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) ins_r = r;
            else                           ins_r = {r[31:7], ops[$urandom_range(0, 10)]};
            drive($urandom_range(0, 9) < 7, ins_r,
                  {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) != 0);
        end

        for (int i = 0; i < 4; i++) drive(0, 32'h0, 64'h0, 1, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idc_stage.md
IDC_STAGE -- requirements
Module: idc_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and imm outputs; legal values 32 and 64 only.
REQ-002 Parameter SKID, default 1, selects the buffer type: 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready = !full || out_ready.
REQ-003 Clock and reset: one clock, reset synchronous and active-low.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 flush  input  1  discard all buffered entries.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  stage can accept.
REQ-009 in_instr  input  32  raw instruction word.
REQ-010 in_pc  input  XLEN  instruction address.
REQ-011 out_valid  output  1  decoded entry valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_pc  output  XLEN  pc of the head entry.
REQ-014 rs1, rs2, rd  output  5 each  register addresses from bits 19:15, 24:20, 11:7.
REQ-015 cmd_op  output  7  opcode, bits 6:0.
REQ-016 func3  output  3  bits 14:12.
REQ-017 func7  output  7  bits 31:25.
REQ-018 imm_type  output  3  immediate class: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-019 imm  output  XLEN  immediate selected by opcode and sign-extended to XLEN.
REQ-020 illegal  output  1  unsupported opcode; port is present only when IDC_ILLEGAL_EN is defined.

Function
REQ-021 Decode SHALL be combinational on in_instr; the results SHALL be registered together with in_pc, giving exactly 1-cycle latency from acceptance to out_valid.
REQ-022 Transfer occurs when valid && ready on either side; accepted entries SHALL leave in acceptance order, none lost or duplicated.
REQ-023 Immediate-class map:
  - LUI 0110111 and AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - BRANCH 1100011 → B.
  - STORE 0100011 → S.
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011 → I.
  - All other opcodes → R, imm = 0.
REQ-024 Immediate construction per RV32I bit layout; bit 31 of the instruction SHALL sign-extend to XLEN (U-type included when XLEN=64).
REQ-025 Occupancy states EMPTY, ONE, TWO (SKID=1) or EMPTY, ONE (SKID=0):
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without drain.
  - ONE→EMPTY on drain without accept.
  - TWO→ONE on drain.
  - Simultaneous accept and drain SHALL hold the state.
REQ-026 SKID=1: in_ready = (state != TWO), driven from a register; out_valid = (state != EMPTY).
REQ-027 out_valid SHALL NOT drop while out_ready is low (no retraction), and payload outputs SHALL remain stable while out_valid && !out_ready.
REQ-028 flush SHALL force state EMPTY next cycle and take priority over a same-cycle accept; the instruction presented in a flush cycle is dropped.
REQ-029 When out_valid=0, payload outputs SHALL hold their last value; the bench SHALL NOT check them.

Reset
REQ-030 rst_n=0 at a clock edge SHALL set state EMPTY, out_valid=0, in_ready=0 during reset and in_ready=1 in the first cycle after release.
REQ-031 Payload registers SHALL reset to 0: imm, out_pc, rs1, rs2, rd, cmd_op, func3, func7, imm_type=R, and illegal=0 when present.
REQ-032 Reset mid-transfer SHALL discard all buffered entries; no out_valid pulse may follow until a new acceptance.

Configuration
REQ-033 Macro IDC_ILLEGAL_EN:
  - Defined: illegal port exists; illegal=1 for any opcode outside REQ-023, or when in_instr[1:0] != 2'b11. The entry is still passed through with imm_type=R and imm=0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

Structure
REQ-034 Package idc_pkg SHALL hold the opcode constants, the imm_type enumeration, and the XLEN legality check.
REQ-035 Sub-module idc_fields SHALL hold the purely combinational field/immediate decode; idc_stage holds only the buffer and handshake.

Verification
REQ-036 XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, rd=1, rs1=0, imm_type=I, imm=0xFFFFFFFF.
REQ-037 XLEN=64, in_instr=0x123452B7 (lui x5) → rd=5, imm_type=U, imm=0x0000000012345000; in_instr=0xFE000EE3 (beq -4) → imm_type=B, imm=0xFFFFFFFFFFFFFFFC.
REQ-038 SKID=1, out_ready=0 for 4 cycles, in_valid=1 with pc 0x0, 0x4, 0x8:
  - in_ready falls after 2 accepts.
  - After out_ready=1, outputs appear in order 0x0, 0x4, then 0x8.
REQ-039 flush asserted with state TWO and in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle instruction never appears.
REQ-040 With IDC_ILLEGAL_EN defined, in_instr=0x0000007F → illegal=1, imm=0; with it undefined the build has no illegal port.
REQ-041 rst_n=0 for 1 cycle while state ONE → out_valid=0 and all payload outputs 0 on the following cycle.
